// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the packed-BCD adder.
//   BCD_W    : bits per BCD digit
//   BCD_MAX  : largest legal digit value
//   BCD_CORR : correction added to a binary digit sum that exceeds BCD_MAX
//   bcd_digit_t : one packed BCD digit
// ---------------------------------------------------------------------------
package bcd_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage : bcd_pkg

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Combinational one-digit BCD adder with decimal carry.
//   a, b : input digits (values above 9 are still processed by the same rule)
//   ci   : decimal carry in
//   sum  : BCD result digit
//   co   : decimal carry out
//   bad  : a or b is not a legal BCD digit (>9)
// ---------------------------------------------------------------------------
module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       ci,
   output bcd_digit_t sum,
   output logic       co,
   output logic       bad
);

   // Five bits wide so that the worst case 15+15+1=31 is not truncated.
   logic [BCD_W:0] bin_sum;
   logic [BCD_W:0] corr_sum;

   // NOTE: every output of this always_comb is assigned on every path, so no
   // latch can be inferred.
   always_comb begin
      bin_sum  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, ci};
      corr_sum = bin_sum + {1'b0, BCD_CORR};
      co       = (bin_sum > {1'b0, BCD_MAX});
      sum      = co ? corr_sum[BCD_W-1:0] : bin_sum[BCD_W-1:0];
      bad      = (a > BCD_MAX) || (b > BCD_MAX);
   end

endmodule : bcd_digit_add

// File: rtl/bcd_adder.sv
// ---------------------------------------------------------------------------
// bcd_adder
// Registered multi-digit packed-BCD adder, 1-cycle latency, one addition per
// cycle. The digit carry chain is purely combinational; the only storage is
// the output register stage.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : bcd1/bcd2/cin are valid this cycle
//   bcd1,bcd2 : packed BCD operands, digit 0 in bits [3:0]
//   cin       : decimal carry into digit 0
//   out_valid : bcdsum/cout/err hold a result captured on the previous edge
//   bcdsum    : packed BCD sum
//   cout      : decimal carry out of the most significant digit
//   err       : some captured operand digit was greater than 9
// ---------------------------------------------------------------------------
module bcd_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [BCD_W*DIGITS-1:0] bcd1,
   input  logic [BCD_W*DIGITS-1:0] bcd2,
   input  logic                    cin,
   output logic                    out_valid,
   output logic [BCD_W*DIGITS-1:0] bcdsum,
   output logic                    cout,
   output logic                    err
);

   // carry[i] feeds digit i; carry[DIGITS] is the decimal carry out.
   logic [DIGITS:0]             carry;
   logic [DIGITS-1:0]           bad_digit;
   logic [BCD_W*DIGITS-1:0]     bcdsum_d;
   logic                        cout_d;
   logic                        err_d;

   logic                        out_valid_q;
   logic [BCD_W*DIGITS-1:0]     bcdsum_q;
   logic                        cout_q;
   logic                        err_q;

   assign carry[0] = cin;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_add u_digit (
         .a   (bcd1[BCD_W*i +: BCD_W]),
         .b   (bcd2[BCD_W*i +: BCD_W]),
         .ci  (carry[i]),
         .sum (bcdsum_d[BCD_W*i +: BCD_W]),
         .co  (carry[i+1]),
         .bad (bad_digit[i])
      );
   end

   assign cout_d = carry[DIGITS];
   assign err_d  = |bad_digit;

   // NOTE: the output registers are reset so that a cleared adder presents a
   // defined all-zero result rather than stale data; sequential state is
   // written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         bcdsum_q    <= '0;
         cout_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         // Without a new operand the previous result is held.
         if (in_valid) begin
            bcdsum_q <= bcdsum_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign bcdsum    = bcdsum_q;
   assign cout      = cout_q;
   assign err       = err_q;

endmodule : bcd_adder

// File: tb/tb_bcd_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_adder
// Self-checking bench for bcd_adder. Two instances (DIGITS=1 and DIGITS=4)
// share clock, reset and in_valid. Expected results come from a per-digit
// decimal reference model with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_bcd_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;

   logic [3:0]  a1, b1, s1;
   logic        c1, co1, er1, ov1;

   logic [15:0] a4, b4, s4;
   logic        c4, co4, er4, ov4;

   int n_checks = 0;
   int n_errors = 0;

   // Expected output state of each instance.
   logic        e_valid;
   logic [15:0] e_s1, e_s4;
   logic        e_co1, e_co4, e_er1, e_er4;

   bcd_adder #(.DIGITS(1)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .bcd1     (a1),
      .bcd2     (b1),
      .cin      (c1),
      .out_valid(ov1),
      .bcdsum   (s1),
      .cout     (co1),
      .err      (er1)
   );

   bcd_adder #(.DIGITS(4)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .bcd1     (a4),
      .bcd2     (b4),
      .cin      (c4),
      .out_valid(ov4),
      .bcdsum   (s4),
      .cout     (co4),
      .err      (er4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Decimal reference: each digit sum above nine produces a carry and keeps
   // the low four bits of (sum + 6); invalid digits follow the same rule.
   function automatic void bcd_ref(input int digits, input logic [15:0] a,
                                   input logic [15:0] b, input logic ci,
                                   output logic [15:0] s, output logic co,
                                   output logic er);
      int carry;
      int da, db, t;
      s     = '0;
      er    = 1'b0;
      carry = int'(ci);
      for (int i = 0; i < digits; i++) begin
         da = int'(a[4*i +: 4]);
         db = int'(b[4*i +: 4]);
         t  = da + db + carry;
         if (da > 9 || db > 9) er = 1'b1;
         if (t > 9) begin
            s[4*i +: 4] = 4'((t + 6) % 16);
            carry = 1;
         end else begin
            s[4*i +: 4] = 4'(t);
            carry = 0;
         end
      end
      co = (carry != 0);
   endfunction

   function automatic logic [15:0] rand_bcd4(input bit allow_bad);
      logic [15:0] v;
      for (int i = 0; i < 4; i++)
         if (allow_bad && $urandom_range(0, 5) == 0)
            v[4*i +: 4] = 4'($urandom_range(10, 15));
         else
            v[4*i +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, " d1.out_valid"}, 16'(ov1), 16'(e_valid));
      check({tag, " d1.bcdsum"},    16'(s1),  e_s1);
      check({tag, " d1.cout"},      16'(co1), 16'(e_co1));
      check({tag, " d1.err"},       16'(er1), 16'(e_er1));
      check({tag, " d4.out_valid"}, 16'(ov4), 16'(e_valid));
      check({tag, " d4.bcdsum"},    s4,       e_s4);
      check({tag, " d4.cout"},      16'(co4), 16'(e_co4));
      check({tag, " d4.err"},       16'(er4), 16'(e_er4));
   endtask

   task automatic clear_expected();
      e_valid = 1'b0;
      e_s1 = '0; e_co1 = 1'b0; e_er1 = 1'b0;
      e_s4 = '0; e_co4 = 1'b0; e_er4 = 1'b0;
   endtask

   // At a falling edge: check the result of the previous step, then present
   // the next operands and record what the following rising edge must yield.
   task automatic step(input string tag, input logic v,
                       input logic [3:0] na1, input logic [3:0] nb1,
                       input logic nc1, input logic [15:0] na4,
                       input logic [15:0] nb4, input logic nc4);
      @(negedge clk);
      check_all(tag);
      in_valid = v;
      a1 = na1; b1 = nb1; c1 = nc1;
      a4 = na4; b4 = nb4; c4 = nc4;
      e_valid = v;
      if (v) begin
         bcd_ref(1, {12'h000, na1}, {12'h000, nb1}, nc1, e_s1, e_co1, e_er1);
         bcd_ref(4, na4, nb4, nc4, e_s4, e_co4, e_er4);
      end
   endtask

   initial begin
      logic       rv, rc1, rc4;
      logic [3:0] ra1, rb1;

      in_valid = 1'b0;
      a1 = '0; b1 = '0; c1 = 1'b0;
      a4 = '0; b4 = '0; c4 = 1'b0;
      clear_expected();

      // Asynchronous reset before any clock edge.
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2 check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, back-to-back.
      step("idle",      1'b1, 4'h1, 4'h3, 1'b0, 16'h9999, 16'h0001, 1'b0);
      step("1+3",       1'b1, 4'h5, 4'h1, 1'b1, 16'h1234, 16'h8765, 1'b1);
      check("lit 1+3 sum",       16'(s1), 16'h0004);
      check("lit 9999+1 sum",    s4,      16'h0000);
      check("lit 9999+1 cout",   16'(co4), 16'h0001);
      step("5+1+1",     1'b1, 4'h5, 4'h9, 1'b0, 16'h0456, 16'h0123, 1'b0);
      step("5+9",       1'b1, 4'h6, 4'h7, 1'b0, 16'h4321, 16'h5678, 1'b0);
      check("lit 0456+0123 sum", s4, 16'h0579);
      step("6+7",       1'b1, 4'h9, 4'h6, 1'b1, 16'h0000, 16'h0000, 1'b0);
      step("9+6+1",     1'b1, 4'h1, 4'h8, 1'b0, 16'h0909, 16'h0909, 1'b1);
      step("1+8",       1'b1, 4'h9, 4'h9, 1'b1, 16'h5000, 16'h5000, 1'b0);
      step("9+9+1",     1'b1, 4'hA, 4'h1, 1'b0, 16'hA0B0, 16'h0001, 1'b0);
      step("A+1",       1'b1, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      check("lit A+1 sum",  16'(s1),  16'h0001);
      check("lit A+1 err",  16'(er1), 16'h0001);
      step("F+F+1",     1'b0, 4'h2, 4'h2, 1'b0, 16'h1111, 16'h1111, 1'b0);
      check("lit F+F+1 sum", 16'(s1), 16'h0005);
      step("hold1",     1'b0, 4'h3, 4'h3, 1'b0, 16'h2222, 16'h2222, 1'b0);
      step("hold2",     1'b1, 4'h2, 4'h4, 1'b0, 16'h0099, 16'h0001, 1'b0);

      // Reset between edges while out_valid is high; operands offered during
      // reset must be discarded.
      @(negedge clk);
      check_all("pre-reset");
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a1 = 4'h7; b1 = 4'h7; c1 = 1'b1;
      a4 = 16'h7777; b4 = 16'h7777; c4 = 1'b1;
      clear_expected();
      #1 check_all("mid-reset");
      @(posedge clk);
      #1 check_all("reset-edge");
      @(negedge clk);
      rst_n    = 1'b0;
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;

      step("post-reset", 1'b1, 4'h4, 4'h5, 1'b0, 16'h0456, 16'h0123, 1'b0);

      // Randomized traffic.
      for (int r = 0; r < 60; r++) begin
         rv  = ($urandom_range(0, 3) != 0);
         ra1 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                           : 4'($urandom_range(0, 9));
         rb1 = 4'($urandom_range(0, 9));
         rc1 = 1'($urandom_range(0, 1));
         rc4 = 1'($urandom_range(0, 1));
         step("random", rv, ra1, rb1, rc1, rand_bcd4(1'b1),
              rand_bcd4(r[0]), rc4);
      end
      step("drain", 1'b0, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      check_all("final");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_bcd_adder
